membus_arbiter: RTL
===================

MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 4, meaning read-ID FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter RESP_TIMEOUT, default 256, meaning cycles without s_resp before a forced response.
REQ-003 SHALL have port clk_gen, in, 1, clock; all logic on its rising edge.
REQ-004 SHALL have port srst, in, 1, reset, synchronous, active-high.
REQ-005 SHALL have ports m0_req/m0_we, in, 1 each, master 0 request and write flag; m0_addr, in, 32; m0_be, in, 4; m0_wdata, in, 32.
REQ-006 SHALL have ports m0_ack, out, 1, accept; m0_resp, out, 1, read response; m0_rdata, out, 32.
REQ-007 SHALL have port set m1_*, identical to m0_*, for master 1.
REQ-008 SHALL have ports s_req/s_we, out, 1; s_addr, out, 32; s_be, out, 4; s_wdata, out, 32, to the slave bus.
REQ-009 SHALL have ports s_ack, in, 1; s_resp, in, 1; s_rdata, in, 32, from the slave bus.
REQ-010 SHALL have ports outst_cnt, out, clog2(MAX_OUTST)+1, pending reads; err_timeout, out, 1, sticky; err_spurious, out, 1, sticky; clr_err, in, 1, clears both flags.

Function
REQ-011 SHALL grant one master per cycle, combinationally, from m0_req, m1_req and a registered priority bit prio (0 = master 0 preferred).
REQ-012 SHALL, when only one master requests, grant it regardless of prio; when both request, grant the master named by prio.
REQ-013 SHALL drive s_req, s_we, s_addr, s_be and s_wdata from the granted master; s_req = 0 when no grant.
REQ-014 SHALL drive mX_ack = s_ack AND s_req AND (grant == X); the ungranted master's ack = 0.
REQ-015 SHALL, on an accepted transfer (s_req & s_ack), set prio to the master not granted (round-robin); otherwise hold prio.
REQ-016 SHALL, on an accepted read, push the granted master ID into the FIFO (depth MAX_OUTST) in the same edge.
REQ-017 SHALL, when the FIFO is full, suppress grant to any master presenting a read (s_req = 0 for it); writes from the other master remain grantable.
REQ-018 SHALL, on s_resp with the FIFO non-empty, pop the head ID and drive m<ID>_resp = 1 and m<ID>_rdata = s_rdata combinationally in that cycle; the other master's resp = 0, rdata = 0.
REQ-019 SHALL, on s_resp with the FIFO empty, drop the response (no mX_resp) and set err_spurious.
REQ-020 SHALL, on a push and pop in the same cycle, keep outst_cnt unchanged; the FIFO pointers wrap modulo MAX_OUTST.
REQ-021 SHALL count cycles while the FIFO is non-empty and s_resp = 0, resetting the count on any s_resp or when the FIFO is empty.
REQ-022 SHALL, when the count reaches RESP_TIMEOUT, pop the head in that cycle, drive m<ID>_resp = 1 with m<ID>_rdata = 32'hDEAD_BEEF, set err_timeout and reset the count.
REQ-023 SHALL give clr_err lower priority than a same-cycle set event (set wins).
REQ-024 SHALL make outst_cnt equal to the FIFO occupancy, registered.

Reset
REQ-025 SHALL, on srst, clear prio to 0, empty the FIFO (outst_cnt = 0), zero the timeout count, and clear err_timeout and err_spurious.
REQ-026 SHALL give srst priority over all events; responses pending at reset are discarded, and any later s_resp for them is treated as spurious.
REQ-027 SHALL hold mX_ack/mX_resp = 0 and s_req = 0 combinationally in every cycle srst = 1.

Verification
REQ-028 SHALL check: both masters request writes continuously with s_ack = 1 -> grants alternate m0, m1, m0, ... and s_addr follows the granted master.
REQ-029 SHALL check: m1 read to 0x80000004, then m0 read, then s_resp with 0x11 followed by s_resp with 0x22 -> m1_rdata = 0x11 and m0_rdata = 0x22, in order.
REQ-030 SHALL check: 4 reads accepted with no response (MAX_OUTST = 4) -> outst_cnt = 4; a fifth read is not acked; a concurrent write on the other master is acked.
REQ-031 SHALL check: 1 read pending and no s_resp for 256 cycles -> a forced resp with 0xDEADBEEF to the owner, err_timeout = 1, outst_cnt = 0.
REQ-032 SHALL check: s_resp with an empty FIFO -> no mX_resp and err_spurious = 1; clr_err pulse -> 0.
REQ-033 SHALL check: srst with 2 reads pending -> outst_cnt = 0 the next cycle; a later s_resp sets err_spurious.

Source files
------------

// File: rtl/membus_arbiter.sv
// Two-master round-robin arbiter onto a single slave bus, with an in-order
// read-ID FIFO that routes responses back and forces a response on timeout.
module membus_arbiter #(
  parameter int MAX_OUTST    = 4,
  parameter int RESP_TIMEOUT = 256
) (
  input  logic                        clk_gen,
  input  logic                        srst,
  input  logic                        m0_req,
  input  logic                        m0_we,
  input  logic [31:0]                 m0_addr,
  input  logic [3:0]                  m0_be,
  input  logic [31:0]                 m0_wdata,
  output logic                        m0_ack,
  output logic                        m0_resp,
  output logic [31:0]                 m0_rdata,
  input  logic                        m1_req,
  input  logic                        m1_we,
  input  logic [31:0]                 m1_addr,
  input  logic [3:0]                  m1_be,
  input  logic [31:0]                 m1_wdata,
  output logic                        m1_ack,
  output logic                        m1_resp,
  output logic [31:0]                 m1_rdata,
  output logic                        s_req,
  output logic                        s_we,
  output logic [31:0]                 s_addr,
  output logic [3:0]                  s_be,
  output logic [31:0]                 s_wdata,
  input  logic                        s_ack,
  input  logic                        s_resp,
  input  logic [31:0]                 s_rdata,
  output logic [$clog2(MAX_OUTST):0]  outst_cnt,
  output logic                        err_timeout,
  output logic                        err_spurious,
  input  logic                        clr_err
);

  localparam int AW = $clog2(MAX_OUTST);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  logic                 prio;
  logic [MAX_OUTST-1:0] id_q;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        cnt;
  logic [TW-1:0]        tcnt;

  logic full;
  logic empty;
  logic el0;
  logic el1;
  logic gnt0;
  logic gnt1;
  logic acc;
  logic push;
  logic pop;
  logic tmo;
  logic spur;
  logic head;

  assign full  = (cnt == CW'(MAX_OUTST));
  assign empty = (cnt == '0);
  assign head  = id_q[rd_ptr];

  // A read is ineligible while the ID FIFO is full; writes stay eligible.
  assign el0  = m0_req & ~(full & ~m0_we);
  assign el1  = m1_req & ~(full & ~m1_we);
  assign gnt1 = ~srst & el1 & (~el0 | prio);
  assign gnt0 = ~srst & el0 & ~gnt1;

  assign s_req   = gnt0 | gnt1;
  assign s_we    = gnt1 ? m1_we    : (gnt0 & m0_we);
  assign s_addr  = gnt1 ? m1_addr  : m0_addr;
  assign s_be    = gnt1 ? m1_be    : m0_be;
  assign s_wdata = gnt1 ? m1_wdata : m0_wdata;

  assign acc    = s_req & s_ack;
  assign m0_ack = acc & gnt0;
  assign m1_ack = acc & gnt1;
  assign push   = acc & ~s_we;

  assign tmo  = ~srst & ~empty & ~s_resp &
                (tcnt == TW'(RESP_TIMEOUT - 1));
  assign pop  = ~srst & ~empty & (s_resp | tmo);
  assign spur = ~srst & s_resp & empty;

  always_comb begin
    m0_resp  = 1'b0;
    m0_rdata = '0;
    m1_resp  = 1'b0;
    m1_rdata = '0;
    if (pop) begin
      if (head) begin
        m1_resp  = 1'b1;
        m1_rdata = s_resp ? s_rdata : 32'hDEAD_BEEF;
      end else begin
        m0_resp  = 1'b1;
        m0_rdata = s_resp ? s_rdata : 32'hDEAD_BEEF;
      end
    end
  end

  always_ff @(posedge clk_gen) begin
    if (srst) begin
      prio         <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      tcnt         <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (acc)
        prio <= gnt0;
      if (push) begin
        id_q[wr_ptr] <= gnt1;
        wr_ptr       <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      cnt  <= cnt + CW'(push) - CW'(pop);
      tcnt <= (empty | s_resp | tmo) ? '0 : tcnt + TW'(1);
      err_timeout  <= tmo  | (err_timeout  & ~clr_err);
      err_spurious <= spur | (err_spurious & ~clr_err);
    end
  end

  assign outst_cnt = cnt;

endmodule
